arbitro_vc_d: RTL and testbench
===============================

Name: arbitro_vc_d

Overview:
- Weighted round-robin arbiter/scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the QoS path.
- Each cycle it pops at most one word from one VC FIFO and routes it to D0 or D1 according to the word header, honouring destination almost-full backpressure.
- Sits after the Main→VC demux and before D0/D1.
- Gated by the `active` output of the path's init/idle/active/error control FSM.

Parameters:
- BW, 6, word width; bits [BW-1:BW-2] are the header, [BW-3:0] the payload.
- WEIGHT0, 3, maximum consecutive VC0 grants while VC1 is eligible (range 1..15).
- CNTW, 8, width of the per-destination word counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  arbitration allowed (driven by `active` of the control FSM).
- VC0_empty  in  1  VC0 FIFO empty.
- VC1_empty  in  1  VC1 FIFO empty.
- VC0_data_out  in  BW  VC0 head word (first-word-fall-through).
- VC1_data_out  in  BW  VC1 head word (first-word-fall-through).
- D0_almost_full  in  1  D0 at or above its HIGH threshold.
- D1_almost_full  in  1  D1 at or above its HIGH threshold.
- VC0_rd  out  1  pop VC0 (combinational, same cycle as grant).
- VC1_rd  out  1  pop VC1 (combinational).
- D0_wr  out  1  push D0 (registered).
- D1_wr  out  1  push D1 (registered).
- D0_data_in  out  BW  word to D0 (registered).
- D1_data_in  out  BW  word to D1 (registered).
- grant  out  2  registered one-hot grant of the last cycle: 01=VC0, 10=VC1, 00=none.
- arb_state  out  2  00 IDLE, 01 ARB, 10 STALL.
- D0_count  out  CNTW  words written to D0 since reset; wraps.
- D1_count  out  CNTW  words written to D1 since reset; wraps.

Behaviour:
- **Destination:** dest(word) = word[BW-2]; 0→D0, 1→D1. Example: 6'b01_0001 goes to D1.
- **Eligibility:** eligX = enable & ~VCX_empty & ~Dk_almost_full, where k = dest(VCX_data_out).
- **Grant selection:**
  - Both eligible: grant VC0 if credit0 < WEIGHT0, else grant VC1.
  - One eligible: grant that one.
  - None eligible: no grant.
- **credit0 (4-bit register):**
  - +1 on each VC0 grant, saturating at WEIGHT0.
  - Cleared on any VC1 grant.
  - Unchanged when there is no grant.
- **Pop:** VCX_rd is asserted combinationally in the grant cycle; it is never asserted for an empty VC. At most one of VC0_rd/VC1_rd is high in any cycle.
- **Push (latency 1):** the cycle after a grant, Dk_wr=1 and Dk_data_in = the granted word. Exactly one D write per grant, so D0_wr and D1_wr are never high together. When there is no grant, both _wr are 0 and the data_in outputs hold their last value.
- **Counters:** Dk_count += 1 on each Dk_wr, wrapping modulo 2^CNTW.
- **FSM (registered, evaluated each edge):**
  - IDLE → ARB when any eligX; IDLE → STALL when enable and some VC is non-empty but none is eligible.
  - ARB → ARB while a grant occurs; → STALL when VCs are non-empty but none eligible; → IDLE when both VCs are empty or enable=0.
  - STALL → ARB when any eligible; → IDLE when enable=0 or both VCs are empty.
  - The grant itself depends only on the eligibility equations, not on the state; arb_state is status only.
- **enable deassert:** takes effect the same cycle (no new pops). A word granted in the previous cycle is still written.
- **Almost-full margin:** the D FIFO HIGH threshold must leave ≥1 free slot. One in-flight write can land after almost_full rises; this block does not compensate for it.
- **Reset:**
  - Outputs: all _rd/_wr=0, data_in=0, grant=00, arb_state=IDLE, counts=0.
  - Internal: credit0=0, pending write discarded.
  - Reset asserted mid-transfer drops the in-flight push (the word is lost); the bench accounts for this.

Test Plan:
1. **Reset:** reset=1 for 2 cycles with VC0 non-empty and enable=1 → VC0_rd=0, all outputs at reset values; first pop occurs on the cycle after reset falls.
2. **Single VC routing:** VC0 holds 01_0001, 00_1111, 01_1100; D FIFOs not full → VC0_rd high 3 consecutive cycles; D1_wr, D0_wr, D1_wr one cycle later with matching data; D1_count=2, D0_count=1.
3. **Weighting:** both VCs hold 8 words, WEIGHT0=3, no backpressure → grant sequence VC0,VC0,VC0,VC1,VC0,VC0,VC0,VC1,…
4. **Backpressure:**
   - VC0 head targets D1 with D1_almost_full=1; VC1 head targets D0 → only VC1 is granted.
   - When VC1 empties → arb_state=STALL, no rd.
   - D1_almost_full falls → VC0 is granted next cycle.
5. **enable gating:** enable drops during ARB → no pop that cycle, the previously granted word is still written, arb_state=IDLE next cycle.
6. **Wrap:** 256 words to D0 with CNTW=8 → D0_count returns to 0.

Source files
------------

// File: rtl/arbitro_vc_d.sv
// arbitro_vc_d: weighted round-robin scheduler that pops at most one word per
// cycle from VC0/VC1 and pushes it one cycle later into D0 or D1 according to
// the word header, honouring destination almost-full backpressure.
module arbitro_vc_d #(
  parameter int BW      = 6,
  parameter int WEIGHT0 = 3,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            VC0_empty,
  input  logic            VC1_empty,
  input  logic [BW-1:0]   VC0_data_out,
  input  logic [BW-1:0]   VC1_data_out,
  input  logic            D0_almost_full,
  input  logic            D1_almost_full,
  output logic            VC0_rd,
  output logic            VC1_rd,
  output logic            D0_wr,
  output logic            D1_wr,
  output logic [BW-1:0]   D0_data_in,
  output logic [BW-1:0]   D1_data_in,
  output logic [1:0]      grant,
  output logic [1:0]      arb_state,
  output logic [CNTW-1:0] D0_count,
  output logic [CNTW-1:0] D1_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARB   = 2'b01,
    STALL = 2'b10
  } state_t;

  localparam logic [3:0] WEIGHT0_C = 4'(WEIGHT0);

  // VC0 grant credit saturates at the weight so VC1 wins the next contested slot.
  function automatic logic [3:0] credit_sat_inc(input logic [3:0] c);
    return (c >= WEIGHT0_C) ? WEIGHT0_C : c + 4'd1;
  endfunction

  // Word counters wrap naturally modulo 2^CNTW.
  function automatic logic [CNTW-1:0] count_wrap_inc(input logic [CNTW-1:0] c);
    return c + CNTW'(1);
  endfunction

  // Header bit BW-2 selects the destination: 0 -> D0, 1 -> D1.
  function automatic logic dest_is_d1(input logic [BW-1:0] w);
    return w[BW-2];
  endfunction

  state_t        state_p1;
  logic [3:0]    credit0;

  logic          blocked0_p0;
  logic          blocked1_p0;
  logic          elig0_p0;
  logic          elig1_p0;
  logic          gnt0_p0;
  logic          gnt1_p0;
  logic          vld_p0;
  logic [BW-1:0] word_p0;
  logic          dest_p0;
  logic          any_elig_p0;
  logic          any_pending_p0;

  // ---- stage p0: eligibility, grant selection and pop (combinational) ----
  // Reset gates eligibility so no pop can happen while the block is held in reset.
  always_comb begin
    blocked0_p0    = dest_is_d1(VC0_data_out) ? D1_almost_full : D0_almost_full;
    blocked1_p0    = dest_is_d1(VC1_data_out) ? D1_almost_full : D0_almost_full;
    elig0_p0       = ~reset & enable & ~VC0_empty & ~blocked0_p0;
    elig1_p0       = ~reset & enable & ~VC1_empty & ~blocked1_p0;
    gnt0_p0        = elig0_p0 & (~elig1_p0 | (credit0 < WEIGHT0_C));
    gnt1_p0        = elig1_p0 & ~gnt0_p0;
    vld_p0         = gnt0_p0 | gnt1_p0;
    word_p0        = gnt0_p0 ? VC0_data_out : VC1_data_out;
    dest_p0        = dest_is_d1(word_p0);
    any_elig_p0    = elig0_p0 | elig1_p0;
    any_pending_p0 = enable & (~VC0_empty | ~VC1_empty);
  end

  assign VC0_rd    = gnt0_p0;
  assign VC1_rd    = gnt1_p0;
  assign arb_state = state_p1;

  // ---- stage p1: registered push strobes, grant record and credit ----
  // A reset here discards any write that was granted in the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      D0_wr   <= 1'b0;
      D1_wr   <= 1'b0;
      grant   <= 2'b00;
      credit0 <= 4'd0;
    end else begin
      D0_wr <= vld_p0 & ~dest_p0;
      D1_wr <= vld_p0 & dest_p0;
      grant <= {gnt1_p0, gnt0_p0};
      if (gnt1_p0) begin
        credit0 <= 4'd0;
      end else if (gnt0_p0) begin
        credit0 <= credit_sat_inc(credit0);
      end
    end
  end

  // Destination data registers load only on a write to that destination, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      D0_data_in <= '0;
      D1_data_in <= '0;
    end else if (vld_p0) begin
      if (dest_p0) begin
        D1_data_in <= word_p0;
      end else begin
        D0_data_in <= word_p0;
      end
    end
  end

  // Count each push as it is accepted by the destination FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      D0_count <= '0;
      D1_count <= '0;
    end else begin
      if (D0_wr) D0_count <= count_wrap_inc(D0_count);
      if (D1_wr) D1_count <= count_wrap_inc(D1_count);
    end
  end

  // Status FSM; it reports activity and never influences the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= IDLE;
    end else begin
      case (state_p1)
        IDLE: begin
          if (any_elig_p0)         state_p1 <= ARB;
          else if (any_pending_p0) state_p1 <= STALL;
        end
        ARB: begin
          if (any_elig_p0)         state_p1 <= ARB;
          else if (any_pending_p0) state_p1 <= STALL;
          else                     state_p1 <= IDLE;
        end
        STALL: begin
          if (any_elig_p0)          state_p1 <= ARB;
          else if (!any_pending_p0) state_p1 <= IDLE;
        end
        default: state_p1 <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_vc_d.sv
// tb_arbitro_vc_d: directed and randomized stimulus for arbitro_vc_d, checked
// every cycle against a queue-based behavioural model of the scheduler.
module tb_arbitro_vc_d;

  localparam int BW      = 6;
  localparam int WEIGHT0 = 3;
  localparam int CNTW    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            VC0_empty;
  logic            VC1_empty;
  logic [BW-1:0]   VC0_data_out;
  logic [BW-1:0]   VC1_data_out;
  logic            D0_almost_full;
  logic            D1_almost_full;
  logic            VC0_rd;
  logic            VC1_rd;
  logic            D0_wr;
  logic            D1_wr;
  logic [BW-1:0]   D0_data_in;
  logic [BW-1:0]   D1_data_in;
  logic [1:0]      grant;
  logic [1:0]      arb_state;
  logic [CNTW-1:0] D0_count;
  logic [CNTW-1:0] D1_count;

  arbitro_vc_d #(.BW(BW), .WEIGHT0(WEIGHT0), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
    .VC0_data_out(VC0_data_out), .VC1_data_out(VC1_data_out),
    .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
    .VC0_rd(VC0_rd), .VC1_rd(VC1_rd), .D0_wr(D0_wr), .D1_wr(D1_wr),
    .D0_data_in(D0_data_in), .D1_data_in(D1_data_in),
    .grant(grant), .arb_state(arb_state),
    .D0_count(D0_count), .D1_count(D1_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: VC FIFO contents plus what the destinations should see.
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  int            tests = 0;
  int            fails = 0;
  int            m_run0;     // VC0 grants since the last VC1 grant, capped at WEIGHT0
  bit            m_wr0, m_wr1;
  logic [BW-1:0] m_data0, m_data1;
  int            m_cnt0, m_cnt1;
  int            m_state;    // 0 idle, 1 arbitrating, 2 stalled
  int            m_grant;    // 0 none, 1 VC0, 2 VC1

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit dest_full(input logic [BW-1:0] w);
    return w[BW-2] ? D1_almost_full : D0_almost_full;
  endfunction

  function automatic bit can_send(input int v);
    if (reset || !enable) return 0;
    if (v == 0) return (q0.size() != 0) && !dest_full(q0[0]);
    return (q1.size() != 0) && !dest_full(q1[0]);
  endfunction

  function automatic int pick();
    bit e0, e1;
    e0 = can_send(0);
    e1 = can_send(1);
    if (e0 && e1) return (m_run0 < WEIGHT0) ? 1 : 2;
    if (e0) return 1;
    if (e1) return 2;
    return 0;
  endfunction

  task automatic drive();
    VC0_empty    = (q0.size() == 0);
    VC1_empty    = (q1.size() == 0);
    VC0_data_out = BW'($urandom);
    VC1_data_out = BW'($urandom);
    if (q0.size() != 0) VC0_data_out = q0[0];
    if (q1.size() != 0) VC1_data_out = q1[0];
  endtask

  // One clock: drive from the queues, check pops, advance the model, check registered outputs.
  task automatic cycle();
    int            g;
    bit            ae, pend;
    logic [BW-1:0] w;
    drive();
    #2;
    g    = pick();
    ae   = can_send(0) || can_send(1);
    pend = enable && (q0.size() != 0 || q1.size() != 0);
    check("VC0_rd", 32'(VC0_rd), 32'(g == 1));
    check("VC1_rd", 32'(VC1_rd), 32'(g == 2));
    @(posedge clk);
    if (reset) begin
      m_run0 = 0; m_wr0 = 0; m_wr1 = 0; m_data0 = '0; m_data1 = '0;
      m_cnt0 = 0; m_cnt1 = 0; m_state = 0; m_grant = 0;
    end else begin
      if (m_wr0) m_cnt0 = (m_cnt0 + 1) % (1 << CNTW);
      if (m_wr1) m_cnt1 = (m_cnt1 + 1) % (1 << CNTW);
      m_wr0 = 0;
      m_wr1 = 0;
      if (g != 0) begin
        w = (g == 1) ? q0.pop_front() : q1.pop_front();
        if (w[BW-2]) begin m_wr1 = 1; m_data1 = w; end
        else         begin m_wr0 = 1; m_data0 = w; end
      end
      if (g == 1) m_run0 = (m_run0 < WEIGHT0) ? m_run0 + 1 : WEIGHT0;
      if (g == 2) m_run0 = 0;
      m_state = ae ? 1 : (pend ? 2 : 0);
      m_grant = g;
    end
    #1;
    check("D0_wr",      32'(D0_wr),      32'(m_wr0));
    check("D1_wr",      32'(D1_wr),      32'(m_wr1));
    check("D0_data_in", 32'(D0_data_in), 32'(m_data0));
    check("D1_data_in", 32'(D1_data_in), 32'(m_data1));
    check("grant",      32'(grant),      (m_grant == 1) ? 32'd1 : (m_grant == 2) ? 32'd2 : 32'd0);
    check("arb_state",  32'(arb_state),  32'(m_state));
    check("D0_count",   32'(D0_count),   32'(m_cnt0));
    check("D1_count",   32'(D1_count),   32'(m_cnt1));
  endtask

  task automatic drain();
    D0_almost_full = 0;
    D1_almost_full = 0;
    enable = 1;
    for (int i = 0; i < 64 && (q0.size() != 0 || q1.size() != 0); i++) cycle();
    repeat (2) cycle();
  endtask

  initial begin
    logic [BW-1:0] w;
    m_run0 = 0; m_wr0 = 0; m_wr1 = 0; m_data0 = '0; m_data1 = '0;
    m_cnt0 = 0; m_cnt1 = 0; m_state = 0; m_grant = 0;

    // Reset held two cycles with VC0 loaded and enable high; then single-VC routing.
    reset = 1; enable = 1; D0_almost_full = 0; D1_almost_full = 0;
    q0.push_back(6'b01_0001);
    q0.push_back(6'b00_1111);
    q0.push_back(6'b01_1100);
    repeat (2) cycle();
    reset = 0;
    repeat (5) cycle();
    check("route_D1_count", 32'(D1_count), 32'd2);
    check("route_D0_count", 32'(D0_count), 32'd1);
    check("route_D1_last",  32'(D1_data_in), 32'(6'b01_1100));

    // Weighting: both VCs hold 8 words, no backpressure.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(BW'($urandom));
      q1.push_back(BW'($urandom));
    end
    repeat (20) cycle();
    drain();

    // Backpressure: VC0 head blocked on D1, VC1 feeds D0 until empty.
    q0.push_back(6'b01_0011);
    q1.push_back(6'b00_0101);
    q1.push_back(6'b00_0110);
    D1_almost_full = 1;
    repeat (3) cycle();
    check("bp_stall_state", 32'(arb_state), 32'd2);
    D1_almost_full = 0;
    repeat (3) cycle();
    drain();

    // Enable gating during arbitration.
    for (int i = 0; i < 4; i++) q0.push_back(BW'($urandom));
    repeat (2) cycle();
    enable = 0;
    cycle();
    check("en_idle_state", 32'(arb_state), 32'd0);
    cycle();
    enable = 1;
    drain();

    // Randomized traffic, backpressure, enable and one mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 16) q0.push_back(BW'($urandom));
      if ($urandom_range(0, 2) == 0 && q1.size() < 16) q1.push_back(BW'($urandom));
      D0_almost_full = ($urandom_range(0, 4) == 0);
      D1_almost_full = ($urandom_range(0, 4) == 0);
      enable         = ($urandom_range(0, 9) != 0);
      reset          = (i == 200);
      cycle();
    end
    reset = 0;
    drain();

    // Counter wrap: 256 words to D0 from a fresh reset.
    reset = 1;
    cycle();
    reset = 0;
    for (int i = 0; i < 256; i++) begin
      w = BW'($urandom);
      w[BW-1:BW-2] = 2'b00;
      q0.push_back(w);
    end
    repeat (260) cycle();
    check("wrap_D0_count", 32'(D0_count), 32'd0);
    check("wrap_D1_count", 32'(D1_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
